// File: rtl/adder_measure_pkg.sv
// adder_measure_pkg: shared state encoding, field widths and saturating add for the measurement controller
package adder_measure_pkg;
  localparam int SETTLE_W = 4;
  localparam int ACC_CNT_W = 32;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DRAIN, S_CAPTURE} state_t;
  function automatic logic [ACC_CNT_W:0] sat_add(input logic [ACC_CNT_W-1:0] a, input logic [ACC_CNT_W-1:0] b);
    logic [ACC_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_CNT_W] ? {1'b1, {ACC_CNT_W{1'b1}}} : s;
  endfunction
endpackage

// File: rtl/meas_window_timer.sv
// meas_window_timer: loadable down-counter timing the SETTLE, RUN and DRAIN phases
module meas_window_timer #(
  parameter int W = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt_q;
  assign zero = cnt_q == '0;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else if (load) cnt_q <= val;
    else if (en && !zero) cnt_q <= cnt_q - W'(1);
  end
endmodule

// File: rtl/adder_measure_ctrl.sv
// adder_measure_ctrl: sequences one ring-oscillator adder delay measurement; ADDER_MEASURE_CTRL_ACCUM_EN sums 2^ACC_LOG2 passes
module adder_measure_ctrl
  import adder_measure_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 32,
  parameter int WIN_W    = 16,
  parameter int SETTLE   = 4,
  parameter int ACC_LOG2 = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_cfg,
  input  logic [WIDTH-1:0] b_cfg,
  input  logic [WIN_W-1:0] window,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             ring_en,
  output logic             cnt_clear,
  output logic             cnt_en,
  input  logic [CNT_W-1:0] cnt_value,
  output logic [CNT_W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam int PW = ACC_LOG2 + 1;
`ifdef ADDER_MEASURE_CTRL_ACCUM_EN
  localparam int unsigned PASSES = 1 << ACC_LOG2;
`else
  localparam int unsigned PASSES = 1;
`endif
  state_t state, nxt;
  logic [WIN_W-1:0] win_q, t_val;
  logic [PW-1:0] pass_q;
  logic [CNT_W-1:0] cap_val;
  logic t_zero, t_load, accept, cap, last, cap_ovf;
  assign accept = state == S_IDLE && start && !abort;
  assign cap = state == S_CAPTURE && !abort;
  assign last = pass_q == PW'(PASSES - 1);
`ifdef ADDER_MEASURE_CTRL_ACCUM_EN
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W:0] sum;
  assign sum = sat_add(acc_q, cnt_value);
  assign cap_val = sum[CNT_W-1:0];
  assign cap_ovf = sum[CNT_W] | (&cnt_value);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || accept) acc_q <= '0;
    else if (cap) acc_q <= sum[CNT_W-1:0];
  end
`else
  assign cap_val = cnt_value;
  assign cap_ovf = &cnt_value;
`endif
  always_comb begin
    nxt = state;
    if (abort) nxt = S_IDLE;
    else case (state)
      S_IDLE:    if (start) nxt = S_LOAD;
      S_LOAD:    nxt = S_SETTLE;
      S_SETTLE:  if (t_zero) nxt = S_RUN;
      S_RUN:     if (t_zero) nxt = S_DRAIN;
      S_DRAIN:   if (t_zero) nxt = S_CAPTURE;
      S_CAPTURE: nxt = last ? S_IDLE : S_LOAD;
      default:   nxt = S_IDLE;
    endcase
  end
  // timer holds phase length minus one, loaded on the edge entering the phase
  assign t_load = nxt != state && (nxt == S_SETTLE || nxt == S_RUN || nxt == S_DRAIN);
  assign t_val = nxt == S_RUN ? (win_q == '0 ? '0 : win_q - WIN_W'(1)) : WIN_W'(SETTLE_W'(SETTLE - 1));
  meas_window_timer #(.W(WIN_W)) u_timer (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .load(t_load),
    .en(state != S_IDLE),
    .val(t_val),
    .zero(t_zero)
  );
  // outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      win_q <= '0;
      pass_q <= '0;
      adder_a <= '0;
      adder_b <= '0;
      ring_en <= 1'b0;
      cnt_clear <= 1'b0;
      cnt_en <= 1'b0;
      result <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      ring_en <= nxt == S_SETTLE || nxt == S_RUN;
      cnt_en <= nxt == S_RUN;
      cnt_clear <= nxt == S_LOAD;
      busy <= nxt != S_IDLE;
      done <= cap && last;
      overflow <= accept ? 1'b0 : overflow | (cap & cap_ovf);
      pass_q <= accept ? '0 : cap ? pass_q + PW'(1) : pass_q;
      if (accept) begin
        adder_a <= a_cfg;
        adder_b <= b_cfg;
        win_q <= window;
      end
      if (cap && last) result <= cap_val;
    end
  end
endmodule

// File: tb/tb_adder_measure_ctrl.sv
// tb_adder_measure_ctrl: randomized self-checking bench with a behavioural ring-counter and timing model
module tb_adder_measure_ctrl;
  localparam int WIDTH = 32, CNT_W = 32, WIN_W = 16, SETTLE = 4, ACC_LOG2 = 2;
`ifdef ADDER_MEASURE_CTRL_ACCUM_EN
  localparam int PASSES = 1 << ACC_LOG2;
`else
  localparam int PASSES = 1;
`endif
  logic wb_clk_i = 0, wb_rst_i = 0, start = 0, abort = 0;
  logic [WIDTH-1:0] a_cfg = '0, b_cfg = '0, adder_a, adder_b;
  logic [WIN_W-1:0] window = '0;
  logic [CNT_W-1:0] cnt_value = '0, result, cnt = '0, last_res = '0;
  logic ring_en, cnt_clear, cnt_en, busy, done, overflow;
  int checks = 0, errors = 0, cyc = 0, n_en = 0, n_done = 0, inc = 3;
  bit force_ones = 0;

  adder_measure_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE), .ACC_LOG2(ACC_LOG2)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .a_cfg(a_cfg), .b_cfg(b_cfg), .window(window), .adder_a(adder_a), .adder_b(adder_b),
    .ring_en(ring_en), .cnt_clear(cnt_clear), .cnt_en(cnt_en), .cnt_value(cnt_value),
    .result(result), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;
  // ring counter model: clears while cnt_clear is high, gains inc per gated period
  always @(negedge wb_clk_i) begin
    if (cnt_clear === 1'b1) cnt = '0;
    else if (cnt_en === 1'b1) cnt = cnt + CNT_W'(inc);
    cnt_value = force_ones ? '1 : cnt;
    if (cnt_en === 1'b1) n_en++;
    if (done === 1'b1) n_done++;
  end

  function automatic longint exp_sum(input int w, input int inc_v);
    return longint'(PASSES) * longint'(inc_v) * longint'(w == 0 ? 1 : w);
  endfunction
  // latency in periods, LOAD being period 1 after the accepting edge
  function automatic int exp_lat(input int w);
    return PASSES * (2 + 2 * SETTLE + (w == 0 ? 1 : w)) + 1;
  endfunction

  task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int w, output int acc);
    @(negedge wb_clk_i);
    a_cfg = a; b_cfg = b; window = WIN_W'(w); start = 1;
    @(posedge wb_clk_i); #1;
    acc = cyc;
    @(negedge wb_clk_i);
    start = 0;
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge wb_clk_i);
      if (done === 1'b1) begin got = 1; break; end
    end
  endtask

  task automatic run_meas(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int w, input int inc_v, input bit ones);
    int acc, d0, e0, lat;
    bit got, eo;
    longint s;
    logic [CNT_W-1:0] er;
    s = exp_sum(w, inc_v);
    eo = ones || s > 64'sh0_FFFF_FFFF;
    er = eo ? '1 : CNT_W'(s);
    inc = inc_v; force_ones = ones; d0 = n_done; e0 = n_en;
    pulse_start(a, b, w, acc);
    wait_done(got);
    lat = cyc - acc + 1;
    checks++; if (!got) begin errors++; $display("FAIL %s_done_timeout got=0 want=1", nm); end
    checks++; if (lat !== exp_lat(w)) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, exp_lat(w)); end
    checks++; if (result !== er) begin errors++; $display("FAIL %s_result got=%h want=%h", nm, result, er); end
    checks++; if (overflow !== eo) begin errors++; $display("FAIL %s_overflow got=%b want=%b", nm, overflow, eo); end
    checks++; if (adder_a !== a || adder_b !== b) begin errors++; $display("FAIL %s_operands got=%h/%h want=%h/%h", nm, adder_a, adder_b, a, b); end
    checks++; if (n_en - e0 !== PASSES * (w == 0 ? 1 : w)) begin errors++; $display("FAIL %s_gate_cycles got=%0d want=%0d", nm, n_en - e0, PASSES * (w == 0 ? 1 : w)); end
    @(negedge wb_clk_i);
    checks++; if ({done, busy} !== 2'b00 || n_done - d0 !== 1) begin errors++; $display("FAIL %s_single_done done/busy=%b%b pulses=%0d want 00 and 1", nm, done, busy, n_done - d0); end
    last_res = er; force_ones = 0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checks++; if ({ring_en, cnt_clear, cnt_en, busy, done, overflow} !== 6'b0) begin errors++; $display("FAIL reset_flags got=%b want=000000", {ring_en, cnt_clear, cnt_en, busy, done, overflow}); end
    checks++; if (adder_a !== '0 || adder_b !== '0) begin errors++; $display("FAIL reset_operands got=%h/%h want=0/0", adder_a, adder_b); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    last_res = '0;
  endtask

  task automatic test_basic();
    run_meas("basic", 32'h0000FFFF, 32'h00000001, 100, 3, 0);
  endtask

  task automatic test_zero_window();
    run_meas("zero_win", 32'h12345678, 32'h9ABCDEF0, 0, 3, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_meas($sformatf("rand%0d", i), $urandom, $urandom, $urandom_range(1, 40), $urandom_range(1, 1000), 0);
  endtask

  task automatic test_abort_run();
    int acc, d0, k;
    d0 = n_done; inc = 3; k = 0;
    pulse_start(32'hA5A5A5A5, 32'h5A5A5A5A, 100, acc);
    for (int i = 0; i < 2000 && k < 50; i++) begin
      @(negedge wb_clk_i);
      if (cnt_en === 1'b1) k++;
    end
    checks++; if (k !== 50) begin errors++; $display("FAIL abort_reach_run got=%0d want=50", k); end
    abort = 1;
    @(posedge wb_clk_i); #1;
    checks++; if ({busy, ring_en, cnt_en} !== 3'b000) begin errors++; $display("FAIL abort_run_outputs got=%b want=000", {busy, ring_en, cnt_en}); end
    @(negedge wb_clk_i);
    abort = 0;
    repeat (300) @(negedge wb_clk_i);
    checks++; if (n_done !== d0 || result !== last_res) begin errors++; $display("FAIL abort_run_no_done pulses=%0d result=%h want 0 and %h", n_done - d0, result, last_res); end
  endtask

  task automatic test_abort_capture();
    int acc, d0;
    d0 = n_done; inc = 7;
    pulse_start(32'h1, 32'h2, 8, acc);
    for (int i = 0; i < 2000 && cyc != acc + exp_lat(8) - 2; i++) @(negedge wb_clk_i);
    abort = 1;
    @(posedge wb_clk_i); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_capture_outputs got=%b want=00", {busy, done}); end
    @(negedge wb_clk_i);
    abort = 0;
    repeat (20) @(negedge wb_clk_i);
    checks++; if (n_done !== d0 || result !== last_res) begin errors++; $display("FAIL abort_capture_result pulses=%0d result=%h want 0 and %h", n_done - d0, result, last_res); end
  endtask

  task automatic test_start_busy();
    int acc, d0, lat;
    bit got;
    d0 = n_done; inc = 5;
    pulse_start(32'hCAFE0001, 32'h0000BEEF, 20, acc);
    for (int j = 0; j < 3; j++) begin
      repeat (7) @(negedge wb_clk_i);
      a_cfg = $urandom; b_cfg = $urandom; window = 16'd3; start = 1;
      @(negedge wb_clk_i);
      start = 0;
    end
    wait_done(got);
    lat = cyc - acc + 1;
    checks++; if (!got || lat !== exp_lat(20)) begin errors++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, exp_lat(20)); end
    checks++; if (result !== CNT_W'(exp_sum(20, 5)) || adder_a !== 32'hCAFE0001) begin errors++; $display("FAIL busy_start_result got=%h/%h want=%h/cafe0001", result, adder_a, CNT_W'(exp_sum(20, 5))); end
    repeat (200) @(negedge wb_clk_i);
    checks++; if (n_done - d0 !== 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_one_done pulses=%0d busy=%b want 1 and 0", n_done - d0, busy); end
    last_res = CNT_W'(exp_sum(20, 5));
  endtask

  task automatic test_overflow();
    int acc;
    bit got;
    run_meas("ovf", 32'hFFFFFFFF, 32'h1, 5, 1, 1);
    repeat (20) @(negedge wb_clk_i);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    start = 1; abort = 1;
    @(posedge wb_clk_i); #1;
    checks++; if ({busy, overflow} !== 2'b01) begin errors++; $display("FAIL start_abort_idle busy/ovf=%b want=01", {busy, overflow}); end
    @(negedge wb_clk_i);
    start = 0; abort = 0; inc = 2;
    pulse_start(32'h3, 32'h4, 5, acc);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_start got=%b want=0", overflow); end
    wait_done(got);
    checks++; if (!got || result !== CNT_W'(exp_sum(5, 2)) || overflow !== 1'b0) begin errors++; $display("FAIL ovf_after_rerun result=%h ovf=%b want=%h 0", result, overflow, CNT_W'(exp_sum(5, 2))); end
    last_res = CNT_W'(exp_sum(5, 2));
  endtask

`ifdef ADDER_MEASURE_CTRL_ACCUM_EN
  task automatic test_accum();
    run_meas("accum", 32'h10, 32'h20, 10, 1, 0);
    run_meas("accum_sat", 32'h10, 32'h20, 10, 200000000, 0);
  endtask
`endif

  task automatic test_reset_mid_settle();
    int acc;
    inc = 3;
    pulse_start(32'hDEADBEEF, 32'h0BADF00D, 30, acc);
    for (int i = 0; i < 100 && !(ring_en === 1'b1 && cnt_en === 1'b0); i++) @(negedge wb_clk_i);
    checks++; if ({ring_en, cnt_en} !== 2'b10) begin errors++; $display("FAIL rst_reach_settle got=%b want=10", {ring_en, cnt_en}); end
    wb_rst_i = 1;
    @(posedge wb_clk_i); #1;
    checks++; if ({ring_en, cnt_clear, cnt_en, busy, done, overflow} !== 6'b0 || adder_a !== '0 || adder_b !== '0 || result !== '0) begin
      errors++; $display("FAIL rst_mid_settle flags=%b a=%h b=%h result=%h want all 0", {ring_en, cnt_clear, cnt_en, busy, done, overflow}, adder_a, adder_b, result);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_window();
    test_random();
    test_abort_run();
    test_abort_capture();
    test_start_busy();
    test_overflow();
`ifdef ADDER_MEASURE_CTRL_ACCUM_EN
    test_accum();
`endif
    test_reset_mid_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
